// File: rtl/audio_in.sv
// audio_in: I2S receiver turning an external bitstream into locked, length-checked
// signed 16-bit stereo samples in the clk domain.
module audio_in #(
  parameter int CLK_RATE       = 24576000,
  parameter int TIMEOUT_CYCLES = CLK_RATE / 12000,
  parameter int MIN_SLOT       = 16,
  parameter int MAX_SLOT       = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i2s_bclk,
  input  logic        i2s_lrclk,
  input  logic        i2s_din,
  input  logic        mute,
  output logic [15:0] out_l,
  output logic [15:0] out_r,
  output logic        sample_valid,
  output logic        locked,
  output logic        slot_err
);
  localparam logic [1:0] SEARCH = 2'd0, LEFT = 2'd1, RIGHT = 2'd2;
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] TMAX = IW'(TIMEOUT_CYCLES);
  logic [1:0] bclk_s, lr_s, din_s, state, cnt, cnt_nx;
  logic bclk_d, lr_prev, rise, lr, din, closing, legal;
  logic [5:0] n, n_cl, nl, len_prev;
  logic [15:0] sh, sh_cl, word_l;
  logic [IW-1:0] idle;
  assign lr = lr_s[1];
  assign din = din_s[1];
  assign rise = bclk_s[1] & ~bclk_d;
  assign closing = lr != lr_prev;
  // n_cl/sh_cl describe the slot including the bit sampled this rise
  always_comb begin
    n_cl = n == 6'd63 ? n : n + 6'd1;
    sh_cl = sh;
    if (n < 6'd16) sh_cl[4'd15 - n[3:0]] = din;
    legal = int'(n_cl) >= MIN_SLOT && int'(n_cl) <= MAX_SLOT;
    cnt_nx = (nl == n_cl && nl == len_prev) ? (cnt == 2'd2 ? cnt : cnt + 2'd1) : 2'd1;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      {bclk_s, lr_s, din_s, bclk_d, lr_prev} <= '0;
      state <= SEARCH;
      n <= '0;
      sh <= '0;
      word_l <= '0;
      nl <= '0;
      len_prev <= '0;
      cnt <= '0;
      idle <= '0;
      out_l <= '0;
      out_r <= '0;
      sample_valid <= 1'b0;
      locked <= 1'b0;
      slot_err <= 1'b0;
    end else begin
      bclk_s <= {bclk_s[0], i2s_bclk};
      lr_s <= {lr_s[0], i2s_lrclk};
      din_s <= {din_s[0], i2s_din};
      bclk_d <= bclk_s[1];
      sample_valid <= 1'b0;
      slot_err <= 1'b0;
      if (rise) begin
        idle <= '0;
        lr_prev <= lr;
        n <= (closing || state == SEARCH) ? '0 : n_cl;
        sh <= (closing || state == SEARCH) ? '0 : sh_cl;
        if (state == SEARCH) begin
          if (lr_prev && !lr) state <= LEFT;
        end else if (closing && !legal) begin
          slot_err <= 1'b1;
          locked <= 1'b0;
          cnt <= '0;
          state <= SEARCH;
        end else if (closing && state == LEFT) begin
          word_l <= sh_cl;
          nl <= n_cl;
          state <= RIGHT;
        end else if (closing && state == RIGHT) begin
          cnt <= cnt_nx;
          locked <= cnt_nx == 2'd2;
          len_prev <= n_cl;
          state <= LEFT;
          if (cnt_nx == 2'd2) begin
            out_l <= mute ? '0 : word_l;
            out_r <= mute ? '0 : sh_cl;
            sample_valid <= 1'b1;
          end
        end
      end else if (idle != TMAX) begin
        idle <= idle + 1'b1;
        // stalled bit clock: drop lock once, then hold until bclk resumes
        if (idle == TMAX - 1'b1) begin
          locked <= 1'b0;
          out_l <= '0;
          out_r <= '0;
          cnt <= '0;
          state <= SEARCH;
          n <= '0;
          sh <= '0;
        end
      end
    end
endmodule

// File: tb/tb_audio_in.sv
// tb_audio_in: randomized I2S stream against a slot-level behavioural model.
module tb_audio_in;
  logic clk = 0, reset = 1, bclk = 0, lrclk = 0, din = 0, mute = 0, probe = 0;
  logic [15:0] out_l, out_r;
  logic sample_valid, locked, slot_err;
  int checks = 0, fails = 0, got_err = 0, exp_err = 0;
  int m_st, m_nl, m_plen, m_cnt;
  bit m_prev, m_locked;
  bit m_bits[$];
  logic [15:0] m_wl, m_ol, m_or;
  logic [31:0] exp_q[$];
  logic [31:0] mon_e;

  audio_in dut (
    .clk(clk), .reset(reset), .i2s_bclk(bclk), .i2s_lrclk(lrclk), .i2s_din(din), .mute(mute),
    .out_l(out_l), .out_r(out_r), .sample_valid(sample_valid), .locked(locked), .slot_err(slot_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_st = 0; m_nl = 0; m_plen = 0; m_cnt = 0; m_prev = 0; m_locked = 0;
    m_wl = 0; m_ol = 0; m_or = 0;
    m_bits.delete();
    exp_q.delete();
  endtask

  task automatic m_timeout();
    m_locked = 0; m_ol = 0; m_or = 0; m_cnt = 0; m_st = 0;
    m_bits.delete();
  endtask

  // one received bit: slots are bit lists, closed by an lrclk change on their LSB
  task automatic m_bit(input bit lr, input bit d);
    int len;
    logic [15:0] w;
    if (m_st == 0) begin
      if (m_prev && !lr) begin m_st = 1; m_bits.delete(); end
    end else begin
      m_bits.push_back(d);
      if (lr != m_prev) begin
        len = m_bits.size();
        w = '0;
        for (int i = 0; i < 16 && i < len; i++) w[15-i] = m_bits[i];
        m_bits.delete();
        if (len < 16 || len > 32) begin
          exp_err++; m_locked = 0; m_cnt = 0; m_st = 0;
        end else if (m_st == 1) begin
          m_nl = len; m_wl = w; m_st = 2;
        end else begin
          m_cnt = (m_nl == len && len == m_plen) ? (m_cnt < 2 ? m_cnt + 1 : 2) : 1;
          m_plen = len;
          m_locked = m_cnt == 2;
          m_st = 1;
          if (m_locked) begin
            m_ol = mute ? 16'h0 : m_wl;
            m_or = mute ? 16'h0 : w;
            exp_q.push_back({m_ol, m_or});
          end
        end
      end
    end
    m_prev = lr;
  endtask

  task automatic probe_now();
    probe = 1;
    @(negedge clk);
    probe = 0;
  endtask

  task automatic send_bit(input bit lr, input bit d);
    lrclk = lr; din = d;
    repeat (4) @(negedge clk);
    bclk = 1;
    m_bit(lr, d);
    repeat (3) @(negedge clk);
    probe_now();
    bclk = 0;
  endtask

  task automatic send_slot(input int len, input bit [63:0] v, input bit lr_body, input bit lr_last);
    for (int i = 0; i < len; i++) send_bit(i == len - 1 ? lr_last : lr_body, v[len-1-i]);
  endtask

  task automatic send_frame(input int ll, input bit [63:0] lv, input int rl, input bit [63:0] rv);
    send_slot(ll, lv, 0, 1);
    send_slot(rl, rv, 1, 0);
  endtask

  task automatic preamble();
    repeat (3) send_bit(1, 1);
    send_bit(0, 0);
  endtask

  function automatic bit [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  always @(posedge clk) begin
    #1;
    if (sample_valid) begin
      if (exp_q.size() == 0) chk("unexpected_strobe", 32'(sample_valid), 0);
      else begin
        mon_e = exp_q.pop_front();
        chk("strobe_out_l", 32'(out_l), 32'(mon_e[31:16]));
        chk("strobe_out_r", 32'(out_r), 32'(mon_e[15:0]));
      end
    end
    if (slot_err) got_err++;
    if (probe) begin
      chk("locked", 32'(locked), 32'(m_locked));
      chk("out_l", 32'(out_l), 32'(m_ol));
      chk("out_r", 32'(out_r), 32'(m_or));
      chk("slot_err_count", got_err, exp_err);
      chk("missing_strobe", exp_q.size(), 0);
    end
  end

  initial begin
    int len;
    m_reset();
    repeat (2) @(negedge clk);
    chk("reset_out_l", 32'(out_l), 0);
    chk("reset_valid", 32'(sample_valid), 0);
    reset = 0;
    // lock on 32-bit slots
    preamble();
    send_frame(32, {16'h1234, 16'($urandom)}, 32, {16'hABCD, 16'($urandom)});
    chk("lock_frame1_locked", 32'(locked), 0);
    send_frame(32, {16'h1234, 16'($urandom)}, 32, {16'hABCD, 16'($urandom)});
    chk("lock_frame2_locked", 32'(locked), 1);
    chk("lock_frame2_l", 32'(out_l), 32'h1234);
    chk("lock_frame2_r", 32'(out_r), 32'hABCD);
    send_frame(32, rnd64(), 32, rnd64());
    // reset mid-slot
    send_slot(10, rnd64(), 0, 0);
    reset = 1;
    #1;
    chk("midreset_locked", 32'(locked), 0);
    chk("midreset_out_l", 32'(out_l), 0);
    chk("midreset_out_r", 32'(out_r), 0);
    m_reset();
    probe_now();
    reset = 0;
    preamble();
    send_frame(32, rnd64(), 32, rnd64());
    chk("post_reset_frame1_locked", 32'(locked), 0);
    send_frame(32, rnd64(), 32, rnd64());
    // 24-bit truncation
    send_frame(24, 64'h8001FF, 24, 64'h7FFE00);
    send_frame(24, 64'h8001FF, 24, 64'h7FFE00);
    chk("trunc_l", 32'(out_l), 32'h8001);
    chk("trunc_r", 32'(out_r), 32'h7FFE);
    // illegal 12-bit left slot, then relock
    send_frame(12, rnd64(), 24, rnd64());
    chk("illegal_locked", 32'(locked), 0);
    chk("illegal_err_pulses", got_err, 1);
    send_frame(24, rnd64(), 24, rnd64());
    send_frame(24, rnd64(), 24, rnd64());
    chk("relock_locked", 32'(locked), 1);
    // stall timeout
    repeat (2000) @(negedge clk);
    chk("pre_timeout_locked", 32'(locked), 1);
    repeat (100) @(negedge clk);
    m_timeout();
    chk("timeout_locked", 32'(locked), 0);
    chk("timeout_out_l", 32'(out_l), 0);
    probe_now();
    preamble();
    send_frame(32, rnd64(), 32, rnd64());
    send_frame(32, rnd64(), 32, rnd64());
    // mute, then 32 -> 16 slot change
    mute = 1;
    send_frame(32, rnd64(), 32, rnd64());
    chk("mute_locked", 32'(locked), 1);
    chk("mute_out_l", 32'(out_l), 0);
    mute = 0;
    send_frame(16, 64'h5A5A, 16, 64'hC3C3);
    chk("switch16_frame1_locked", 32'(locked), 0);
    send_frame(16, 64'h5A5A, 16, 64'hC3C3);
    chk("switch16_frame2_l", 32'(out_l), 32'h5A5A);
    chk("switch16_frame2_r", 32'(out_r), 32'hC3C3);
    // randomized stream
    len = 16;
    for (int f = 0; f < 24; f++) begin
      if ($urandom_range(0, 4) == 0) len = 16 + 4 * $urandom_range(0, 4);
      mute = $urandom_range(0, 3) == 0;
      case ($urandom_range(0, 9))
        0: send_frame(12, rnd64(), len, rnd64());
        1: send_frame(len, rnd64(), 33, rnd64());
        default: send_frame(len, rnd64(), len, rnd64());
      endcase
    end
    repeat (10) @(negedge clk);
    chk("final_pending", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
